// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl
//   Front-panel controller for the stopwatch. Each of the three raw buttons
//   goes through a 2-flop synchronizer and a counter debouncer. The debounced
//   release of a button is its event. The events drive an
//   IDLE/RUN/PAUSE/LAP state machine and a speed-code stepper.
// Ports
//   clk       system clock
//   rst       synchronous active-low reset
//   btn_ss    raw start/stop button (active-high, asynchronous)
//   btn_lr    raw lap/reset button (active-high, asynchronous)
//   btn_spd   raw speed-select button (active-high, asynchronous)
//   run_en    divider enable, high in RUN and LAP
//   clr       one-cycle pulse that zeroes the time counters
//   lap_hold  display freeze, high only in LAP
//   quick     4-bit divider speed code
//   state     IDLE=00 RUN=01 PAUSE=10 LAP=11
module stopwatch_ctrl #(
  parameter int DEBOUNCE_CYC = 500000,
  parameter int CNT_W        = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_ss,
  input  logic       btn_lr,
  input  logic       btn_spd,
  output logic       run_en,
  output logic       clr,
  output logic       lap_hold,
  output logic [3:0] quick,
  output logic [1:0] state
);

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] RUN   = 2'b01;
  localparam logic [1:0] PAUSE = 2'b10;
  localparam logic [1:0] LAP   = 2'b11;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  // Button lanes: [0]=ss, [1]=lr, [2]=spd
  logic [2:0]            btn;
  logic [2:0]            s1_q, s2_q, lvl_q, fall_q;
  logic [2:0][CNT_W-1:0] cnt_q;

  assign btn = {btn_spd, btn_lr, btn_ss};

  // The debounce counter runs only while the synchronized input disagrees with
  // the debounced level. A single agreeing sample restarts it, so glitches
  // shorter than DEBOUNCE_CYC never flip the level. fall_q is registered.
  // This register stage accounts for the +3 in the release-to-output latency
  // (two synchronizer flops, this flop, and then the FSM registers).
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_q   <= '0;
      s2_q   <= '0;
      lvl_q  <= '0;
      fall_q <= '0;
      cnt_q  <= '0;
    end else begin
      s1_q <= btn;
      s2_q <= s1_q;
      for (int i = 0; i < 3; i++) begin
        fall_q[i] <= 1'b0;
        if (s2_q[i] == lvl_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          lvl_q[i]  <= s2_q[i];
          cnt_q[i]  <= '0;
          fall_q[i] <= lvl_q[i];   // level was 1 and is going to 0: release
        end else begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  logic       ss_ev, lr_ev, spd_ev;
  logic [1:0] state_q, state_d;
  logic [3:0] idx_q, idx_d, quick_q;
  logic       clr_q, clr_d, run_en_q, lap_hold_q;

  assign ss_ev  = fall_q[0];
  assign lr_ev  = fall_q[1];
  assign spd_ev = fall_q[2];

  function automatic logic [3:0] qmap(input logic [3:0] idx);
    case (idx)
      4'd1:    qmap = 4'b1000;
      4'd2:    qmap = 4'b0100;
      4'd3:    qmap = 4'b0010;
      4'd4:    qmap = 4'b0001;
      4'd5:    qmap = 4'b0111;
      4'd6:    qmap = 4'b1011;
      4'd7:    qmap = 4'b1101;
      4'd8:    qmap = 4'b1110;
      default: qmap = 4'b0000;
    endcase
  endfunction

  // ss takes priority: it is checked first in every state, so a coincident lr
  // event is dropped.
  always_comb begin
    state_d = state_q;
    clr_d   = 1'b0;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (ss_ev)      state_d = RUN;
        else if (lr_ev) clr_d   = 1'b1;
      end
      RUN: begin
        if (ss_ev)      state_d = PAUSE;
        else if (lr_ev) state_d = LAP;
      end
      LAP: begin
        if (ss_ev)      state_d = PAUSE;
        else if (lr_ev) state_d = RUN;
      end
      PAUSE: begin
        if (ss_ev) begin
          state_d = RUN;
        end else if (lr_ev) begin
          state_d = IDLE;
          clr_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // The speed step is gated on the pre-transition state.
    if (spd_ev && (state_q == IDLE || state_q == PAUSE))
      idx_d = (idx_q >= 4'd8) ? 4'd0 : idx_q + 4'd1;
  end

  // The outputs are decoded from the next state, so they change on the same
  // edge as state. clr is raised only when going to or staying in IDLE.
  // For this reason clr and run_en are never high together.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      quick_q    <= '0;
      clr_q      <= 1'b0;
      run_en_q   <= 1'b0;
      lap_hold_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      quick_q    <= qmap(idx_d);
      clr_q      <= clr_d;
      run_en_q   <= (state_d == RUN) || (state_d == LAP);
      lap_hold_q <= (state_d == LAP);
    end
  end

  assign state    = state_q;
  assign quick    = quick_q;
  assign clr      = clr_q;
  assign run_en   = run_en_q;
  assign lap_hold = lap_hold_q;

endmodule
